// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode and mux/ALU select encodings shared by control and datapath
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational next-state and control decode for the multicycle controller
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output state_t     o_next,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_next = S_FETCH;
        o_ctrl = '0;
        case (i_state)
            S_IDLE: o_next = S_FETCH;
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
                o_next           = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                case (i_opcode)
                    OP_LW, OP_SW: o_next = S_MEMADR;
                    OP_RTYPE:     o_next = S_EXEC;
                    OP_BEQ:       o_next = S_BRANCH;
                    OP_J:         o_next = S_JUMP;
                    OP_ADDI:      o_next = S_ADDI_EX;
                    default:      o_ctrl.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_next           = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
                o_next          = i_mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
                o_next           = i_mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
                o_next           = S_RWB;
            end
            S_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PC_JUMP;
            end
            S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_next           = S_ADDI_WB;
            end
            S_ADDI_WB: o_ctrl.reg_write = 1'b1;
            default:   o_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main control; IDLE decodes to all-zero outputs so async reset clears them at once
module mc_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (mem_ready),
        .o_next      (w_next),
        .o_ctrl      (w_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    assign {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
            alu_src_a, reg_write, reg_dst, alu_src_b, pc_source, alu_op, illegal_op} = w_ctrl;
    assign state = r_state;

endmodule
